// File: rtl/mem_stage.sv
// MEM stage: decodes loads/stores, accesses a banked byte-lane data RAM with
// optional wait states, and registers results into the MEM/WB pipeline register.

module mem_stage_lane #(
    parameter int AW    = 8,
    parameter int VEC_W = 8
) (
    input  logic             gclk,
    input  logic             we,
    input  logic [AW-1:0]    wordIdx,
    input  logic [VEC_W-1:0] wrData,
    output logic [VEC_W-1:0] rdData
);
    logic [VEC_W-1:0] ram [2**AW];

    always_ff @(posedge gclk) begin
        if (we) ram[wordIdx] <= wrData;
    end

    // Asynchronous read: a load retiring on an edge sees the pre-edge contents.
    assign rdData = ram[wordIdx];
endmodule

module mem_stage #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        ClockInput,
    input  logic        ResetInput,
    input  logic        InValid,
    input  logic [31:0] Instruction,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    output logic        Stall,
    output logic        OutValid,
    output logic [31:0] InstructionOut,
    output logic [31:0] MEMRead,
    output logic [31:0] ALUResultOut,
    output logic        AddrError
);
    localparam int AW        = $clog2(MEM_WORDS);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int CW        = 4;
    localparam logic [CW-1:0] WS = CW'(WAIT_STATES);

    typedef enum logic {IDLE, WAIT} state_t;

    // size: 0 byte, 1 half, 2 word
    typedef struct packed {
        logic       isLoad;
        logic       isStore;
        logic [1:0] size;
        logic       signExt;
    } memOp_t;

    state_t  state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    memOp_t  op;
    logic    isMem, misaligned, retire;
    logic [AW-1:0] wordIdx;
    logic [31:0]   rdWord, extData, loadData;
    logic [7:0]    byteSel;
    logic [15:0]   halfSel;
    logic [NUM_LANES-1:0]            laneWe;
    logic [NUM_LANES-1:0][VEC_W-1:0] laneWData, laneRData;

    always_comb begin
        op = '0;
        case (Instruction[31:26])
            6'h23:   op = '{1'b1, 1'b0, 2'd2, 1'b0};
            6'h20:   op = '{1'b1, 1'b0, 2'd0, 1'b1};
            6'h24:   op = '{1'b1, 1'b0, 2'd0, 1'b0};
            6'h21:   op = '{1'b1, 1'b0, 2'd1, 1'b1};
            6'h25:   op = '{1'b1, 1'b0, 2'd1, 1'b0};
            6'h2B:   op = '{1'b0, 1'b1, 2'd2, 1'b0};
            6'h28:   op = '{1'b0, 1'b1, 2'd0, 1'b0};
            6'h29:   op = '{1'b0, 1'b1, 2'd1, 1'b0};
            default: op = '0;
        endcase
    end

    assign isMem      = op.isLoad | op.isStore;
    assign misaligned = (op.size == 2'd2 && ALUResult[1:0] != 2'b00) ||
                        (op.size == 2'd1 && ALUResult[0]);
    assign wordIdx    = ALUResult[AW+1:2];

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        Stall     = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (InValid) begin
                    if (isMem && WAIT_STATES != 0) begin
                        Stall     = 1'b1;
                        stateNext = WAIT;
                        cntNext   = CW'(1);
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == WS) begin
                    retire    = 1'b1;
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    Stall   = 1'b1;
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Lane k owns byte k of every word; sub-word stores enable only their lanes.
    for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
        localparam logic [1:0] LID = 2'(k);
        logic sel;
        always_comb begin
            case (op.size)
                2'd2:    sel = 1'b1;
                2'd1:    sel = (ALUResult[1] == LID[1]);
                default: sel = (ALUResult[1:0] == LID);
            endcase
            case (op.size)
                2'd2:    laneWData[k] = StoreData[8*k +: 8];
                2'd1:    laneWData[k] = LID[0] ? StoreData[15:8] : StoreData[7:0];
                default: laneWData[k] = StoreData[7:0];
            endcase
            laneWe[k] = retire && op.isStore && !misaligned && sel;
        end

        mem_stage_lane #(.AW(AW), .VEC_W(VEC_W)) uLane (
            .gclk    (ClockInput),
            .we      (laneWe[k]),
            .wordIdx (wordIdx),
            .wrData  (laneWData[k]),
            .rdData  (laneRData[k])
        );
    end

    assign rdWord  = laneRData;
    assign byteSel = laneRData[ALUResult[1:0]];
    assign halfSel = ALUResult[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        case (op.size)
            2'd0:    extData = {{24{op.signExt & byteSel[7]}}, byteSel};
            2'd1:    extData = {{16{op.signExt & halfSel[15]}}, halfSel};
            default: extData = rdWord;
        endcase
        loadData = (op.isLoad && !misaligned) ? extData : 32'h0;
    end

    always_ff @(posedge ClockInput) begin
        if (!ResetInput) begin
            state          <= IDLE;
            cnt            <= '0;
            OutValid       <= 1'b0;
            InstructionOut <= '0;
            MEMRead        <= '0;
            ALUResultOut   <= '0;
            AddrError      <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (retire) begin
                OutValid       <= 1'b1;
                InstructionOut <= Instruction;
                MEMRead        <= loadData;
                ALUResultOut   <= ALUResult;
                AddrError      <= misaligned;
            end else begin
                OutValid       <= 1'b0;
                InstructionOut <= '0;
                MEMRead        <= '0;
                ALUResultOut   <= '0;
                AddrError      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (0 and 3 wait states) driven with directed
// and random ops, checked against a byte-array memory model.

module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid  [2];
    logic [31:0] instr    [2];
    logic [31:0] alu      [2];
    logic [31:0] sd       [2];
    logic        stall    [2];
    logic        outValid [2];
    logic [31:0] instrOut [2];
    logic [31:0] memRead  [2];
    logic [31:0] aluOut   [2];
    logic        addrErr  [2];

    int nTests = 0;
    int nFail  = 0;
    int wsv [2] = '{0, 3};
    logic [7:0] bmem [2][128];

    always #5 clk = ~clk;

    mem_stage #(.MEM_WORDS(256), .WAIT_STATES(0)) dut0 (
        .ClockInput(clk), .ResetInput(rstN), .InValid(inValid[0]),
        .Instruction(instr[0]), .ALUResult(alu[0]), .StoreData(sd[0]),
        .Stall(stall[0]), .OutValid(outValid[0]), .InstructionOut(instrOut[0]),
        .MEMRead(memRead[0]), .ALUResultOut(aluOut[0]), .AddrError(addrErr[0]));

    mem_stage #(.MEM_WORDS(256), .WAIT_STATES(3)) dut1 (
        .ClockInput(clk), .ResetInput(rstN), .InValid(inValid[1]),
        .Instruction(instr[1]), .ALUResult(alu[1]), .StoreData(sd[1]),
        .Stall(stall[1]), .OutValid(outValid[1]), .InstructionOut(instrOut[1]),
        .MEMRead(memRead[1]), .ALUResultOut(aluOut[1]), .AddrError(addrErr[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int opSize(input logic [5:0] op);
        case (op)
            6'h23, 6'h2B:        return 4;
            6'h21, 6'h25, 6'h29: return 2;
            6'h20, 6'h24, 6'h28: return 1;
            default:             return 0;
        endcase
    endfunction

    function automatic bit opIsLoad(input logic [5:0] op);
        return op inside {6'h23, 6'h20, 6'h24, 6'h21, 6'h25};
    endfunction

    function automatic bit opIsStore(input logic [5:0] op);
        return op inside {6'h2B, 6'h28, 6'h29};
    endfunction

    function automatic logic [31:0] loadVal(input int s, input logic [5:0] op, input int b);
        int wb = b & ~3;
        logic [7:0]  by = bmem[s][b];
        logic [15:0] h  = {bmem[s][(b+1) & 127], bmem[s][b]};
        case (op)
            6'h23:   return {bmem[s][wb+3], bmem[s][wb+2], bmem[s][wb+1], bmem[s][wb]};
            6'h20:   return {{24{by[7]}}, by};
            6'h24:   return {24'h0, by};
            6'h21:   return {{16{h[15]}}, h};
            default: return {16'h0, h};
        endcase
    endfunction

    // Drive one op from a negedge, check Stall/bubbles every cycle and the retired fields.
    task automatic issue(input int s, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] got);
        logic [31:0] ins, expRd;
        logic        expErr;
        bit          isMem;
        int          sz, b, lat;
        ins    = {op, 26'($urandom)};
        sz     = opSize(op);
        isMem  = sz != 0;
        b      = int'(addr[6:0]);
        expErr = isMem && (b % sz != 0);
        expRd  = (opIsLoad(op) && !expErr) ? loadVal(s, op, b) : 32'h0;
        lat    = isMem ? wsv[s] + 1 : 1;
        inValid[s] = 1'b1; instr[s] = ins; alu[s] = addr; sd[s] = data;
        for (int c = 0; c < lat; c++) begin
            #1 chk("stall", 32'(stall[s]), 32'(isMem && c < wsv[s]));
            @(posedge clk);
            @(negedge clk);
            if (c < lat - 1) begin
                chk("bubble_valid", 32'(outValid[s]), 32'h0);
                chk("bubble_instr", instrOut[s], 32'h0);
            end
        end
        chk("ret_valid", 32'(outValid[s]), 32'h1);
        chk("ret_instr", instrOut[s], ins);
        chk("ret_memread", memRead[s], expRd);
        chk("ret_alu", aluOut[s], addr);
        chk("ret_addrerr", 32'(addrErr[s]), 32'(expErr));
        got = memRead[s];
        if (opIsStore(op) && !expErr) begin
            for (int k = 0; k < sz; k++) bmem[s][b + k] = data[8*k +: 8];
        end
        inValid[s] = 1'b0;
    endtask

    task automatic bubble(input int s);
        inValid[s] = 1'b0;
        instr[s]   = $urandom;
        alu[s]     = $urandom;
        #1 chk("idle_stall", 32'(stall[s]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("idle_valid", 32'(outValid[s]), 32'h0);
        chk("idle_instr", instrOut[s], 32'h0);
        chk("idle_memread", memRead[s], 32'h0);
        chk("idle_alu", aluOut[s], 32'h0);
        chk("idle_addrerr", 32'(addrErr[s]), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops [13] = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2B, 6'h28,
                                  6'h29, 6'h00, 6'h08, 6'h0C, 6'h0F, 6'h04};
        logic [31:0] got, oldWord, addr;

        rstN = 1'b0;
        for (int s = 0; s < 2; s++) begin
            inValid[s] = 1'b0; instr[s] = '0; alu[s] = '0; sd[s] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_valid", 32'(outValid[s]), 32'h0);
            chk("rst_instr", instrOut[s], 32'h0);
            chk("rst_stall", 32'(stall[s]), 32'h0);
            chk("rst_addrerr", 32'(addrErr[s]), 32'h0);
        end
        rstN = 1'b1;

        // Give the modelled region a known image.
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 32; w++) issue(s, 6'h2B, 32'(4 * w), $urandom, got);

        // Zero wait states: word, byte, half and sub-word store patterns.
        issue(0, 6'h2B, 32'h10, 32'hDEADBEEF, got);
        issue(0, 6'h23, 32'h10, 32'h0, got);  chk("dir_lw", got, 32'hDEADBEEF);
        issue(0, 6'h20, 32'h13, 32'h0, got);  chk("dir_lb", got, 32'hFFFFFFDE);
        issue(0, 6'h24, 32'h13, 32'h0, got);  chk("dir_lbu", got, 32'h000000DE);
        issue(0, 6'h21, 32'h10, 32'h0, got);  chk("dir_lh", got, 32'hFFFFBEEF);
        issue(0, 6'h25, 32'h12, 32'h0, got);  chk("dir_lhu", got, 32'h0000DEAD);
        issue(0, 6'h28, 32'h11, 32'hAB55, got);
        issue(0, 6'h23, 32'h10, 32'h0, got);  chk("dir_sb", got, 32'hDEAD55EF);
        issue(0, 6'h29, 32'h12, 32'h1234CAFE, got);
        issue(0, 6'h23, 32'h410, 32'h0, got); chk("dir_sh_wrap", got, 32'hCAFE55EF);
        issue(0, 6'h23, 32'h12, 32'h0, got);  chk("dir_mis_lw", got, 32'h0);
        bubble(0);

        // Three wait states: load then back-to-back ALU op, misaligned store.
        issue(1, 6'h2B, 32'h20, 32'hA5A5_1234, got);
        issue(1, 6'h23, 32'h20, 32'h0, got);  chk("ws_lw", got, 32'hA5A51234);
        issue(1, 6'h00, 32'h0000_0007, 32'h0, got);
        issue(1, 6'h29, 32'h21, 32'hFFFF, got);
        issue(1, 6'h23, 32'h20, 32'h0, got);  chk("ws_mis_sh", got, 32'hA5A51234);
        bubble(1);

        // Reset while a store is waiting: the write is dropped.
        oldWord = {bmem[1][67], bmem[1][66], bmem[1][65], bmem[1][64]};
        inValid[1] = 1'b1; instr[1] = {6'h2B, 26'h0}; alu[1] = 32'h40; sd[1] = 32'h12345678;
        #1 chk("mid_stall0", 32'(stall[1]), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("mid_stall1", 32'(stall[1]), 32'h1);
        rstN = 1'b0;
        inValid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1 chk("mid_stall_after", 32'(stall[1]), 32'h0);
        chk("mid_valid_after", 32'(outValid[1]), 32'h0);
        @(negedge clk);
        issue(1, 6'h23, 32'h40, 32'h0, got);  chk("mid_old", got, oldWord);

        // Random mix, interleaving idle cycles.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 150; i++) begin
                addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 127));
                if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
                issue(s, ops[$urandom_range(0, 12)], addr, $urandom, got);
                if ($urandom_range(0, 7) == 0) bubble(s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
